// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
//   Groups the request, response and external-ALU signals of alu_sequencer.
//
//   Request  : req_valid, req_ready, req_op, req_cond, req_setf, req_a, req_b
//   ALU      : alu_a, alu_b, alu_sel (to ALU); alu_result, alu_z/n/v (from ALU)
//   Response : rsp_valid, rsp_ready, rsp_result, rsp_skipped
//   Status   : flags {Z,N,V}
//
//   Modports:
//     slave  - the sequencer itself
//     master - the environment: request source, response sink and the ALU
// -----------------------------------------------------------------------------
interface alu_sequencer_if #(
  parameter int N = 32
);
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [2:0]   req_cond;
  logic         req_setf;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;

  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [N-1:0] alu_result;
  logic         alu_z;
  logic         alu_n;
  logic         alu_v;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_skipped;

  logic [2:0]   flags;

  modport slave (
    input  req_valid, req_op, req_cond, req_setf, req_a, req_b,
    output req_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result, alu_z, alu_n, alu_v,
    output rsp_valid, rsp_result, rsp_skipped,
    input  rsp_ready,
    output flags
  );

  modport master (
    output req_valid, req_op, req_cond, req_setf, req_a, req_b,
    input  req_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result, alu_z, alu_n, alu_v,
    input  rsp_valid, rsp_result, rsp_skipped,
    output rsp_ready,
    input  flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Accepts one ALU request at a time, evaluates its condition code against
//   the status register, runs it on an external combinational ALU (one EXEC
//   cycle) or as an N-cycle shift-add multiply that reuses the ALU adder, and
//   holds the result in RESP until the consumer takes it.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous active-high reset
//     bus  - alu_sequencer_if.slave (request / ALU / response / flags)
//
//   Parameter N: operand and result width.
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int N = 32
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_MAX_ALU = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t         state_q, state_d;

  // During MUL, a_q is the multiplicand (shifted left) and b_q the
  // multiplier (shifted right); during EXEC they are the plain operands.
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   result_q, result_d;
  logic [3:0]     op_q, op_d;
  logic           setf_q, setf_d;
  logic           skipped_q, skipped_d;
  logic [2:0]     flags_q, flags_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           accept;
  logic           cond_true;
  logic           op_alu;
  logic           op_mul;
  logic           mul_last;

  assign accept   = bus.req_valid && (state_q == IDLE);
  assign op_alu   = (bus.req_op <= OP_MAX_ALU);
  assign op_mul   = (bus.req_op == OP_MUL);
  assign mul_last = (cnt_q == CW'(N - 1));

  // Condition evaluated against the flags as they stand at acceptance.
  always_comb begin
    cond_true = 1'b0;
    case (bus.req_cond)
      3'd0:    cond_true = 1'b1;         // AL
      3'd1:    cond_true = flags_q[2];   // EQ
      3'd2:    cond_true = !flags_q[2];  // NE
      3'd3:    cond_true = flags_q[1];   // MI
      3'd4:    cond_true = !flags_q[1];  // PL
      3'd5:    cond_true = flags_q[0];   // VS
      3'd6:    cond_true = !flags_q[0];  // VC
      default: cond_true = 1'b0;         // NV
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!cond_true) begin
            state_d = RESP;
          end else if (op_alu) begin
            state_d = EXEC;
          end else if (op_mul) begin
            state_d = MUL;
          end else begin
            state_d = RESP;     // reserved opcode
          end
        end
      end
      EXEC:    state_d = RESP;
      MUL:     if (mul_last) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready   = (state_q == IDLE);
    bus.rsp_valid   = (state_q == RESP);
    bus.rsp_result  = result_q;
    bus.rsp_skipped = skipped_q;
    bus.flags       = flags_q;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_sel     = '0;
    case (state_q)
      EXEC: begin
        bus.alu_a   = a_q;
        bus.alu_b   = b_q;
        bus.alu_sel = op_q;
      end
      MUL: begin
        // The ALU adder forms accumulator + multiplicand each iteration.
        bus.alu_a   = acc_q;
        bus.alu_b   = a_q;
        bus.alu_sel = OP_ADD;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    op_d      = op_q;
    setf_d    = setf_q;
    skipped_d = skipped_q;
    flags_d   = flags_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d       = bus.req_a;
          b_d       = bus.req_b;
          op_d      = bus.req_op;
          setf_d    = bus.req_setf;
          acc_d     = '0;
          cnt_d     = '0;
          skipped_d = !cond_true;
          // Skipped ops report 0, reserved ops report all ones; executed
          // ops overwrite this when they complete.
          if (cond_true && !op_alu && !op_mul) begin
            result_d = '1;
          end else begin
            result_d = '0;
          end
        end
      end
      EXEC: begin
        result_d = bus.alu_result;
        if (setf_q) begin
          flags_d = {bus.alu_z, bus.alu_n, bus.alu_v};
        end
      end
      MUL: begin
        if (b_q[0]) begin
          acc_d = bus.alu_result;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (mul_last) begin
          result_d = acc_d;
          if (setf_q) begin
            flags_d = {(acc_d == '0), acc_d[N-1], 1'b0};
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers; reset abandons any operation in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      op_q      <= '0;
      setf_q    <= 1'b0;
      skipped_q <= 1'b0;
      flags_q   <= '0;
      cnt_q     <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      op_q      <= op_d;
      setf_q    <= setf_d;
      skipped_q <= skipped_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
